// File: rtl/boot_pkg.sv
// Shared definitions for the byte-stream boot loader: FSM encoding,
// error codes and frame geometry.
package boot_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    DATA,
    WRITE,
    CSUM,
    DONE,
    ERR
  } boot_state_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_CSUM    = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_SIZE    = 2'd3;

  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/boot_word_packer.sv
// Assembles MSB-first bytes into instruction words. 'word' already includes
// the byte being accepted, so it is the finished word when word_full is high.
module boot_word_packer
  import boot_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              byte_valid,
  input  logic [7:0]        byte_in,
  output logic [DATA_W-1:0] word,
  output logic              word_full
);

  // Only the three older bytes need storage; the newest comes straight from the input.
  logic [DATA_W-9:0] shift_q;
  logic [1:0]        count_q;

  assign word      = {shift_q, byte_in};
  assign word_full = byte_valid && (count_q == 2'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (byte_valid) begin
      shift_q <= word[DATA_W-9:0];
      count_q <= count_q + 2'd1;
    end
  end

endmodule

// File: rtl/boot_stream_loader.sv
// Loads a checksummed byte-stream program into imem through the core's boot
// port, holding the core in boot until the whole image has been verified.
module boot_stream_loader
  import boot_pkg::*;
#(
  parameter int ADDR_W         = 8,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              boot_up,
  output logic [ADDR_W-1:0] boot_addr,
  output logic [DATA_W-1:0] boot_datai,
  output logic              boot_web,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code
);

  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST =
    TMO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  boot_state_t state_q, state_d;
  logic [1:0]        err_code_d;
  logic [ADDR_W-1:0] idx_q, n_last_q;
  logic [7:0]        sum_q, csum_total;
  logic [TMO_W-1:0]  tmo_q;
  logic              accept, counting, timeout_hit, size_err, start_load;
  logic [DATA_W-1:0] packed_word;
  logic              word_full;

  // rx_ready is high exactly in HDR/DATA/CSUM, so accept implies a byte-taking state.
  assign accept      = rx_valid && rx_ready;
  assign counting    = state_q inside {HDR, DATA, CSUM};
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && counting && !accept && (tmo_q == TMO_LAST);
  assign size_err    = (ADDR_W < 8) && ((rx_data >> ADDR_W) != 8'd0);
  assign csum_total  = sum_q + rx_data;
  assign start_load  = (state_d == HDR) && (state_q != HDR);

  boot_word_packer #(.DATA_W(DATA_W)) u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (start_load),
    .byte_valid (accept && (state_q == DATA)),
    .byte_in    (rx_data),
    .word       (packed_word),
    .word_full  (word_full)
  );

  always_comb begin
    state_d    = state_q;
    err_code_d = err_code;
    case (state_q)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_d    = HDR;
          err_code_d = ERR_NONE;
        end
      end
      HDR: begin
        if (timeout_hit) begin
          state_d    = ERR;
          err_code_d = ERR_TIMEOUT;
        end else if (accept) begin
          if (size_err) begin
            state_d    = ERR;
            err_code_d = ERR_SIZE;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (timeout_hit) begin
          state_d    = ERR;
          err_code_d = ERR_TIMEOUT;
        end else if (word_full) begin
          state_d = WRITE;
        end
      end
      WRITE: state_d = (idx_q == n_last_q) ? CSUM : DATA;
      CSUM: begin
        if (timeout_hit) begin
          state_d    = ERR;
          err_code_d = ERR_TIMEOUT;
        end else if (accept) begin
          if (csum_total == 8'd0) begin
            state_d = DONE;
          end else begin
            state_d    = ERR;
            err_code_d = ERR_CSUM;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      err_code   <= ERR_NONE;
      rx_ready   <= 1'b0;
      boot_up    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      boot_web   <= 1'b1;
      boot_addr  <= '0;
      boot_datai <= '0;
    end else begin
      state_q    <= state_d;
      err_code   <= err_code_d;
      rx_ready   <= state_d inside {HDR, DATA, CSUM};
      boot_up    <= !(state_d inside {IDLE, DONE});
      busy       <= state_d inside {HDR, DATA, WRITE, CSUM};
      done       <= (state_d == DONE);
      err        <= (state_d == ERR);
      boot_web   <= (state_d != WRITE);
      boot_addr  <= (state_d == WRITE) ? idx_q : '0;
      boot_datai <= (state_d == WRITE) ? packed_word : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q    <= '0;
      n_last_q <= '0;
      sum_q    <= '0;
      tmo_q    <= '0;
    end else if (start_load) begin
      idx_q <= '0;
      sum_q <= '0;
      tmo_q <= '0;
    end else begin
      if (accept) begin
        sum_q <= csum_total;
        tmo_q <= '0;
      end else if (counting) begin
        tmo_q <= tmo_q + TMO_W'(1);
      end
      if (accept && (state_q == HDR)) begin
        n_last_q <= ADDR_W'(rx_data);
      end
      if ((state_q == WRITE) && (idx_q != n_last_q)) begin
        idx_q <= idx_q + ADDR_W'(1);
      end
    end
  end

endmodule
